// File: rtl/sd_responder_pkg.sv
// Shared types and constants for the SD block responder.
package sd_responder_pkg;

    typedef enum logic [3:0] {
        UNINIT,
        INIT,
        READY,
        RD_OPEN,
        RD_IDLE,
        RD_BYTE,
        WR_OPEN,
        WR_IDLE,
        WR_BYTE,
        WR_PROG
    } state_t;

    localparam int BLOCK_BYTES = 512;
    localparam int IDX_W       = 10;
    localparam int CNT_W       = 8;

    // Byte index advances but parks at its maximum instead of wrapping.
    function automatic logic [IDX_W-1:0] idx_sat_inc(input logic [IDX_W-1:0] idx);
        return (idx == {IDX_W{1'b1}}) ? idx : idx + 1'b1;
    endfunction

endpackage

// File: rtl/memory_module.sv
// Single-port RAM with one-cycle registered read; write and read share the address.
module memory_module #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR       = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR-1:0]       addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR];

    // Write port plus registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sd_block_responder.sv
// RAM-backed SD card stand-in speaking the byte-streaming block interface.
module sd_block_responder
    import sd_responder_pkg::*;
#(
    parameter logic [31:0] BASE_BLOCK = 32'h0010_0000,
    parameter int          BLOCK_BITS = 3,
    parameter int          INIT_LAT   = 16,
    parameter int          RD_LAT     = 4,
    parameter int          BYTE_LAT   = 2,
    parameter int          WR_LAT     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_rst,
    input  logic [31:0] spi_block_addr,
    input  logic        spi_r_block,
    input  logic        spi_r_byte,
    input  logic        spi_r_multi_block,
    input  logic        spi_w_block,
    input  logic        spi_w_byte,
    input  logic [7:0]  spi_data_in,
    output logic [7:0]  spi_data_out,
    output logic        spi_busy,
    output logic        spi_err,
    output logic        spi_crc_err
);

    localparam int                MEM_AW    = BLOCK_BITS + 9;
    localparam logic [31:0]       NUM_BLKS  = 32'(1 << BLOCK_BITS);
    localparam logic [CNT_W-1:0]  INIT_CNT  = CNT_W'(INIT_LAT - 1);
    localparam logic [CNT_W-1:0]  RD_CNT    = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  BYTE_CNT  = CNT_W'(BYTE_LAT - 1);
    localparam logic [CNT_W-1:0]  WR_CNT    = CNT_W'(WR_LAT - 1);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    busy_reg, busy_next;
    logic                    err_reg, err_next;
    logic [7:0]              data_reg, data_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [BLOCK_BITS-1:0]   blk_reg, blk_next;
    logic                    rd_armed_reg, rd_armed_next;
    logic                    wr_armed_reg, wr_armed_next;

    logic [31:0]             addr_off;
    logic                    mem_we;
    logic [MEM_AW-1:0]       mem_addr;
    logic [7:0]              mem_rdata;

    // The RAM is always addressed by the current block and byte index; a fetch
    // simply reads whatever index is current, a write happens only in the last
    // busy cycle of a write byte, so the two never collide.
    assign mem_addr = {blk_reg, idx_reg[8:0]};

    memory_module #(
        .DATA_WIDTH (8),
        .ADDR       (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (spi_data_in),
        .rdata (mem_rdata)
    );

    assign spi_data_out = data_reg;
    assign spi_busy     = busy_reg;
    assign spi_err      = err_reg;
    assign spi_crc_err  = 1'b0;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= UNINIT;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            data_reg     <= 8'hFF;
            idx_reg      <= '0;
            blk_reg      <= '0;
            rd_armed_reg <= 1'b1;
            wr_armed_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            data_reg     <= data_next;
            idx_reg      <= idx_next;
            blk_reg      <= blk_next;
            rd_armed_reg <= rd_armed_next;
            wr_armed_reg <= wr_armed_next;
        end
    end

    // Next-state logic; every latency state counts the shared counter down to 0
    // and acts on the cycle it reads 0, giving exactly LAT busy cycles.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        err_next      = err_reg;
        data_next     = data_reg;
        idx_next      = idx_reg;
        blk_next      = blk_reg;
        // A request level is honoured once; it must drop before it re-arms.
        rd_armed_next = rd_armed_reg | ~spi_r_byte;
        wr_armed_next = wr_armed_reg | ~spi_w_byte;
        mem_we        = 1'b0;
        addr_off      = spi_block_addr - BASE_BLOCK;

        if (spi_rst) begin
            // Re-initialise from anywhere; an in-flight byte never reaches RAM.
            state_next = INIT;
            cnt_next   = INIT_CNT;
            busy_next  = 1'b1;
            err_next   = 1'b0;
            idx_next   = '0;
            data_next  = 8'hFF;
        end else begin
            case (state_reg)
                UNINIT: begin
                    if (spi_r_block || spi_w_block || spi_r_multi_block) begin
                        err_next = 1'b1;
                    end
                end
                INIT: begin
                    if (cnt_reg == '0) begin
                        busy_next  = 1'b0;
                        state_next = READY;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                READY: begin
                    if (spi_r_block && spi_w_block) begin
                        err_next = 1'b1;
                    end else if (spi_r_multi_block) begin
                        err_next = 1'b1;
                    end else if ((spi_r_block || spi_w_block) && (addr_off >= NUM_BLKS)) begin
                        // Below-base addresses wrap to huge offsets and land here too.
                        err_next = 1'b1;
                    end else if (spi_r_block) begin
                        blk_next      = addr_off[BLOCK_BITS-1:0];
                        idx_next      = '0;
                        cnt_next      = RD_CNT;
                        busy_next     = 1'b1;
                        rd_armed_next = 1'b1;
                        state_next    = RD_OPEN;
                    end else if (spi_w_block) begin
                        blk_next      = addr_off[BLOCK_BITS-1:0];
                        idx_next      = '0;
                        cnt_next      = BYTE_CNT;
                        busy_next     = 1'b1;
                        wr_armed_next = 1'b1;
                        state_next    = WR_OPEN;
                    end
                end
                RD_OPEN: begin
                    if (!spi_r_block) begin
                        busy_next  = 1'b0;
                        state_next = READY;
                    end else if (cnt_reg == '0) begin
                        data_next  = mem_rdata;
                        busy_next  = 1'b0;
                        state_next = RD_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                RD_IDLE: begin
                    if (!spi_r_block) begin
                        state_next = READY;
                    end else if (spi_r_byte && rd_armed_reg) begin
                        rd_armed_next = 1'b0;
                        idx_next      = idx_sat_inc(idx_reg);
                        cnt_next      = BYTE_CNT;
                        busy_next     = 1'b1;
                        state_next    = RD_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (cnt_reg == '0) begin
                        // Past the data payload the card streams CRC/filler bytes.
                        data_next  = (idx_reg < IDX_W'(BLOCK_BYTES)) ? mem_rdata : 8'hFF;
                        busy_next  = 1'b0;
                        state_next = spi_r_block ? RD_IDLE : READY;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                WR_OPEN: begin
                    if (cnt_reg == '0) begin
                        busy_next  = 1'b0;
                        state_next = WR_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                WR_IDLE: begin
                    if (!spi_w_block) begin
                        cnt_next   = WR_CNT;
                        busy_next  = 1'b1;
                        state_next = WR_PROG;
                    end else if (spi_w_byte && wr_armed_reg) begin
                        wr_armed_next = 1'b0;
                        cnt_next      = BYTE_CNT;
                        busy_next     = 1'b1;
                        state_next    = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if (cnt_reg == '0) begin
                        mem_we   = (idx_reg < IDX_W'(BLOCK_BYTES));
                        idx_next = idx_sat_inc(idx_reg);
                        if (spi_w_block) begin
                            busy_next  = 1'b0;
                            state_next = WR_IDLE;
                        end else begin
                            // Session already closed: go straight to programming.
                            cnt_next   = WR_CNT;
                            state_next = WR_PROG;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                WR_PROG: begin
                    if (cnt_reg == '0) begin
                        busy_next  = 1'b0;
                        state_next = READY;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = UNINIT;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: init, block write/read, arming, errors, abort.
module tb_sd_block_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_rst;
    logic [31:0] spi_block_addr;
    logic        spi_r_block;
    logic        spi_r_byte;
    logic        spi_r_multi_block;
    logic        spi_w_block;
    logic        spi_w_byte;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic        spi_busy;
    logic        spi_err;
    logic        spi_crc_err;

    int compared = 0;
    int mismatched = 0;

    sd_block_responder dut (
        .clk               (clk),
        .rst               (rst),
        .spi_rst           (spi_rst),
        .spi_block_addr    (spi_block_addr),
        .spi_r_block       (spi_r_block),
        .spi_r_byte        (spi_r_byte),
        .spi_r_multi_block (spi_r_multi_block),
        .spi_w_block       (spi_w_block),
        .spi_w_byte        (spi_w_byte),
        .spi_data_in       (spi_data_in),
        .spi_data_out      (spi_data_out),
        .spi_busy          (spi_busy),
        .spi_err           (spi_err),
        .spi_crc_err       (spi_crc_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of cycles busy stays high, bounded at 200.
    task automatic wait_idle(output int n);
        n = 0;
        while (spi_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic open_block(input bit wr, input logic [31:0] a, output int n);
        spi_block_addr = a;
        if (wr) spi_w_block = 1'b1;
        else    spi_r_block = 1'b1;
        tick();
        wait_idle(n);
    endtask

    task automatic write_byte(input logic [7:0] d, output int n);
        spi_data_in = d;
        spi_w_byte  = 1'b1;
        tick();
        spi_w_byte  = 1'b0;
        wait_idle(n);
    endtask

    task automatic read_byte(output logic [7:0] d, output int n);
        spi_r_byte = 1'b1;
        tick();
        spi_r_byte = 1'b0;
        wait_idle(n);
        d = spi_data_out;
    endtask

    task automatic pulse_spi_rst(output int n);
        spi_rst = 1'b1;
        tick();
        spi_rst = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        tick();
        tick();
        compared++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b0 || spi_data_out !== 8'hFF || spi_crc_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%b err=%b data=%h crc=%b, want 0 0 ff 0",
                     spi_busy, spi_err, spi_data_out, spi_crc_err);
        end
        rst = 1'b1;
        tick();
        spi_block_addr = 32'h0010_0000;
        spi_r_block = 1'b1;
        tick();
        spi_r_block = 1'b0;
        compared++;
        if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL uninit_rblock_err: got err=%b busy=%b, want err=1 busy=0", spi_err, spi_busy);
        end
        tick();
        pulse_spi_rst(n);
        compared++;
        if (n !== 16) begin
            mismatched++;
            $display("FAIL init_busy_len: got %0d cycles, want 16", n);
        end
        compared++;
        if (spi_err !== 1'b0) begin
            mismatched++;
            $display("FAIL init_err_clear: got err=%b, want 0", spi_err);
        end
        $display("reset/init: init busy=%0d err=%b", n, spi_err);
    endtask

    task automatic test_write_read();
        int n;
        int bad_lat;
        int bad_data;
        logic [7:0] d;
        open_block(1'b1, 32'h0010_0002, n);
        compared++;
        if (n !== 2) begin
            mismatched++;
            $display("FAIL wr_open_busy: got %0d, want 2", n);
        end
        bad_lat = 0;
        for (int i = 0; i < 516; i++) begin
            write_byte(8'(i), n);
            if (n !== 2) bad_lat++;
        end
        compared++;
        if (bad_lat !== 0) begin
            mismatched++;
            $display("FAIL wr_byte_busy: %0d bytes with busy length != 2, want 0", bad_lat);
        end
        spi_w_block = 1'b0;
        tick();
        wait_idle(n);
        compared++;
        if (n !== 8) begin
            mismatched++;
            $display("FAIL wr_prog_busy: got %0d, want 8", n);
        end
        $display("write block 2: 516 bytes, prog busy=%0d", n);

        open_block(1'b0, 32'h0010_0002, n);
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("FAIL rd_open_busy: got %0d, want 4", n);
        end
        compared++;
        if (spi_data_out !== 8'h00) begin
            mismatched++;
            $display("FAIL rd_byte0: got %h, want 00", spi_data_out);
        end
        bad_lat = 0;
        bad_data = 0;
        for (int i = 1; i < 512; i++) begin
            read_byte(d, n);
            if (n !== 2) bad_lat++;
            if (d !== 8'(i)) begin
                if (bad_data == 0) $display("first bad read idx %0d got %h want %h", i, d, 8'(i));
                bad_data++;
            end
        end
        compared++;
        if (bad_lat !== 0) begin
            mismatched++;
            $display("FAIL rd_byte_busy: %0d bytes with busy length != 2, want 0", bad_lat);
        end
        compared++;
        if (bad_data !== 0) begin
            mismatched++;
            $display("FAIL rd_data_1_511: %0d wrong bytes, want 0", bad_data);
        end
        read_byte(d, n);
        compared++;
        if (d !== 8'hFF) begin
            mismatched++;
            $display("FAIL rd_idx512_filler: got %h, want ff", d);
        end
        spi_r_block = 1'b0;
        tick();
        $display("read block 2: byte512=%h", d);
    endtask

    task automatic test_held_rbyte();
        int n;
        int hb;
        logic [7:0] d;
        open_block(1'b0, 32'h0010_0002, n);
        spi_r_byte = 1'b1;
        tick();
        wait_idle(n);
        compared++;
        if (n !== 2 || spi_data_out !== 8'h01) begin
            mismatched++;
            $display("FAIL held_first: got busy=%0d data=%h, want 2 01", n, spi_data_out);
        end
        hb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (spi_busy === 1'b1) hb++;
        end
        compared++;
        if (hb !== 0) begin
            mismatched++;
            $display("FAIL held_no_reaccept: got %0d busy cycles while held, want 0", hb);
        end
        spi_r_byte = 1'b0;
        tick();
        read_byte(d, n);
        compared++;
        if (d !== 8'h02) begin
            mismatched++;
            $display("FAIL held_next_byte: got %h, want 02", d);
        end
        spi_r_block = 1'b0;
        tick();
        $display("held r_byte: one advance, next=%h", d);
    endtask

    task automatic test_bad_addr();
        int n;
        logic [7:0] d;
        spi_block_addr = 32'h0010_0008;
        spi_r_block = 1'b1;
        tick();
        spi_r_block = 1'b0;
        compared++;
        if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL addr_high_err: got err=%b busy=%b, want 1 0", spi_err, spi_busy);
        end
        tick();
        pulse_spi_rst(n);
        compared++;
        if (spi_err !== 1'b0) begin
            mismatched++;
            $display("FAIL addr_high_clear: got err=%b, want 0", spi_err);
        end
        spi_block_addr = 32'h000F_FFFF;
        spi_w_block = 1'b1;
        tick();
        spi_w_block = 1'b0;
        compared++;
        if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL addr_low_err: got err=%b busy=%b, want 1 0", spi_err, spi_busy);
        end
        tick();
        pulse_spi_rst(n);
        open_block(1'b0, 32'h0010_0002, n);
        compared++;
        if (spi_data_out !== 8'h00 || spi_err !== 1'b0) begin
            mismatched++;
            $display("FAIL ram_unchanged_b0: got data=%h err=%b, want 00 0", spi_data_out, spi_err);
        end
        read_byte(d, n);
        compared++;
        if (d !== 8'h01) begin
            mismatched++;
            $display("FAIL ram_unchanged_b1: got %h, want 01", d);
        end
        spi_r_block = 1'b0;
        tick();
        $display("bad addresses: err raised and cleared, RAM intact");
    endtask

    task automatic test_abort_write();
        int n;
        int bad;
        logic [7:0] d;
        logic [7:0] want;
        open_block(1'b1, 32'h0010_0003, n);
        for (int i = 0; i < 512; i++) write_byte(8'(i) ^ 8'hA5, n);
        spi_w_block = 1'b0;
        tick();
        wait_idle(n);
        open_block(1'b1, 32'h0010_0003, n);
        for (int i = 0; i < 100; i++) write_byte(8'(i) + 8'h33, n);
        spi_data_in = 8'(100) + 8'h33;
        spi_w_byte = 1'b1;
        tick();
        spi_w_byte = 1'b0;
        spi_rst = 1'b1;
        tick();
        spi_rst = 1'b0;
        spi_w_block = 1'b0;
        wait_idle(n);
        compared++;
        if (n !== 16) begin
            mismatched++;
            $display("FAIL abort_init_busy: got %0d, want 16", n);
        end
        open_block(1'b0, 32'h0010_0003, n);
        bad = 0;
        d = spi_data_out;
        for (int i = 0; i < 102; i++) begin
            if (i > 0) read_byte(d, n);
            want = (i < 100) ? (8'(i) + 8'h33) : (8'(i) ^ 8'hA5);
            if (d !== want) begin
                if (bad == 0) $display("first bad abort idx %0d got %h want %h", i, d, want);
                bad++;
            end
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL abort_contents: %0d wrong bytes in 0..101, want 0", bad);
        end
        spi_r_block = 1'b0;
        tick();
        $display("abort mid-write at 100: init busy=%0d, old bytes kept from 100", n);
    endtask

    task automatic test_conflicts();
        int n;
        spi_block_addr = 32'h0010_0001;
        spi_r_block = 1'b1;
        spi_w_block = 1'b1;
        tick();
        spi_r_block = 1'b0;
        spi_w_block = 1'b0;
        compared++;
        if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rw_both_err: got err=%b busy=%b, want 1 0", spi_err, spi_busy);
        end
        tick();
        pulse_spi_rst(n);
        compared++;
        if (spi_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rw_both_clear: got err=%b, want 0", spi_err);
        end
        spi_r_multi_block = 1'b1;
        tick();
        spi_r_multi_block = 1'b0;
        compared++;
        if (spi_err !== 1'b1 || spi_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL multi_err: got err=%b busy=%b, want 1 0", spi_err, spi_busy);
        end
        tick();
        compared++;
        if (spi_err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_sticky: got err=%b, want 1", spi_err);
        end
        $display("conflicts: r+w and multi raise err");
    endtask

    initial begin
        rst = 1'b0;
        spi_rst = 1'b0;
        spi_block_addr = '0;
        spi_r_block = 1'b0;
        spi_r_byte = 1'b0;
        spi_r_multi_block = 1'b0;
        spi_w_block = 1'b0;
        spi_w_byte = 1'b0;
        spi_data_in = '0;
        test_reset();
        test_write_read();
        test_held_rbyte();
        test_bad_addr();
        test_abort_write();
        test_conflicts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
